// File: rtl/ah_pl2ddr_cmd_arbiter.sv
// Round-robin arbiter sharing the pl2ddr command FSM port between NUM_REQ requesters.
// Optional per-command watchdog: define AH_PL2DDR_ARB_TIMEOUT_EN.
module ah_pl2ddr_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [31:0]            out_cmd_data,
  output logic                   out_cmd_en,
  input  logic [3:0]             in_cmdfsm_state,
  output logic [2:0]             out_grant_id,
  output logic                   out_busy,
  input  logic                   in_err_clear,
  output logic                   out_timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] FSM_IDLE     = 4'd0;
  localparam logic [3:0] FSM_INTR_ACK = 4'd9;

  typedef enum logic [1:0] {ARB_IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [31:0]     cmd_q, cmd_d;
  logic            win;
  logic [IW-1:0]   win_id;
  logic [31:0]     win_cmd;
  logic            done;
  logic            tmo;

  // Scan starts one past the last winner; nested constant loops keep all selects static.
  always_comb begin
    win     = 1'b0;
    win_id  = '0;
    win_cmd = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win && req_valid[i] && ((int'(last_q) + off) % NUM_REQ == i)) begin
          win     = 1'b1;
          win_id  = IW'(i);
          win_cmd = req_cmd[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    done    = 1'b0;
    case (state_q)
      ARB_IDLE: if (win) begin
        cmd_d   = win_cmd;
        last_d  = win_id;
        grant_d = win_id;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (in_cmdfsm_state == FSM_INTR_ACK) begin
          state_d = WAIT_DONE;
        end else if (tmo) begin
          done    = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      WAIT_DONE: begin
        if (in_cmdfsm_state == FSM_IDLE || tmo) begin
          done    = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
    end
  end

`ifdef AH_PL2DDR_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;

  // Only evaluated where the awaited FSM state has not shown up this cycle.
  assign tmo = (cnt_q == 16'(TIMEOUT_CYCLES - 1)) &&
               ((state_q == WAIT_ACK  && in_cmdfsm_state != FSM_INTR_ACK) ||
                (state_q == WAIT_DONE && in_cmdfsm_state != FSM_IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_ACK || state_q == WAIT_DONE) begin
        cnt_q <= cnt_q + 16'd1;
      end
      err_q <= tmo | (err_q & ~in_err_clear);
    end
  end

  assign out_timeout_err = err_q;
`else
  logic unused_tie;
  assign unused_tie      = in_err_clear | (TIMEOUT_CYCLES < 16);
  assign tmo             = 1'b0;
  assign out_timeout_err = 1'b0;
`endif

  assign out_cmd_en   = (state_q == ISSUE);
  assign out_busy     = (state_q != ARB_IDLE);
  assign out_cmd_data = cmd_q;
  assign out_grant_id = 3'(grant_q);
  assign req_ready    = out_cmd_en ? (NUM_REQ'(1) << grant_q) : '0;
  assign req_done     = done ? (NUM_REQ'(1) << grant_q) : '0;

endmodule

// File: tb/tb_ah_pl2ddr_cmd_arbiter.sv
// Bench for ah_pl2ddr_cmd_arbiter: transaction-level reference model compared every cycle,
// scripted command-FSM responder and directed scenarios with literal expectations.
module tb_ah_pl2ddr_cmd_arbiter;
  localparam int N = 4;
  localparam int T = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [32*N-1:0]  req_cmd = '0;
  logic [N-1:0]     req_ready, req_done;
  logic [31:0]      out_cmd_data;
  logic             out_cmd_en;
  logic [3:0]       st = 4'd0;
  logic [2:0]       out_grant_id;
  logic             out_busy;
  logic             in_err_clear = 1'b0;
  logic             out_timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fsm_pre = 0;
  int fsm_exec = 1;
  bit fsm_hang = 1'b0;
  int grants[$];
  int en_cnt = 0;
  int done_cnt = 0;

  ah_pl2ddr_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .req_done(req_done), .out_cmd_data(out_cmd_data),
    .out_cmd_en(out_cmd_en), .in_cmdfsm_state(st), .out_grant_id(out_grant_id),
    .out_busy(out_busy), .in_err_clear(in_err_clear), .out_timeout_err(out_timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one command in flight at most; a free cycle picks the next
  // valid requester after the previous winner and issues it on the following cycle.
  bit          m_issue, m_inflight, m_acked, m_err;
  int          m_wait, m_last, m_idx;
  logic [2:0]  m_grant;
  logic [31:0] m_data;
  bit          d_now, a_now, t_now;

  initial begin
    m_issue = 0; m_inflight = 0; m_acked = 0; m_err = 0;
    m_wait = 0; m_last = N-1; m_grant = '0; m_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_cmd_en", out_cmd_en, 0);
        chk("rst_busy",   out_busy, 0);
        chk("rst_ready",  req_ready, 0);
        chk("rst_done",   req_done, 0);
        chk("rst_data",   out_cmd_data, 0);
        chk("rst_grant",  out_grant_id, 0);
        chk("rst_err",    out_timeout_err, 0);
        m_issue = 0; m_inflight = 0; m_acked = 0; m_err = 0;
        m_wait = 0; m_last = N-1; m_grant = '0; m_data = '0;
      end else begin
        d_now = 0; a_now = 0; t_now = 0;
        if (m_inflight) begin
          if (!m_acked && st == 4'd9) a_now = 1;
          else if (m_acked && st == 4'd0) d_now = 1;
`ifdef AH_PL2DDR_ARB_TIMEOUT_EN
          else if (m_wait == T-1) begin d_now = 1; t_now = 1; end
`endif
        end
        chk("m_cmd_en", out_cmd_en, m_issue);
        chk("m_ready",  req_ready, m_issue ? (1 << m_grant) : 0);
        chk("m_done",   req_done, d_now ? (1 << m_grant) : 0);
        chk("m_data",   out_cmd_data, m_data);
        chk("m_grant",  out_grant_id, m_grant);
        chk("m_busy",   out_busy, m_issue | m_inflight);
        chk("m_err",    out_timeout_err, m_err);
`ifdef AH_PL2DDR_ARB_TIMEOUT_EN
        m_err = t_now | (m_err & !in_err_clear);
`endif
        if (m_inflight) begin
          m_wait++;
          if (a_now) m_acked = 1;
          if (d_now) m_inflight = 0;
        end else if (m_issue) begin
          m_issue = 0; m_inflight = 1; m_acked = 0; m_wait = 0;
        end else begin
          for (int k = 1; k <= N; k++) begin
            m_idx = (m_last + k) % N;
            if (!m_issue && req_valid[m_idx]) begin
              m_issue = 1; m_last = m_idx; m_grant = 3'(m_idx);
              m_data = req_cmd[32*m_idx +: 32];
            end
          end
        end
      end
    end
  end

  // Event log for literal checks.
  initial forever begin
    @(negedge clk);
    if (rst && out_cmd_en) begin grants.push_back(int'(out_grant_id)); en_cnt++; end
    if (rst && req_done != 0) done_cnt++;
  end

  // Command-FSM responder: optional WAIT_TX stall, then INTR_ACK, execute, IDLE.
  initial forever begin
    @(negedge clk);
    if (rst && out_cmd_en) begin
      @(posedge clk); #1;
      for (int i = 0; i < fsm_pre; i++) begin st = 4'd6; @(posedge clk); #1; end
      if (fsm_hang) begin
        st = 4'd10;
        while (fsm_hang) begin @(posedge clk); #1; end
        st = 4'd0;
      end else begin
        st = 4'd9; @(posedge clk); #1;
        for (int i = 0; i < fsm_exec; i++) begin st = 4'd1; @(posedge clk); #1; end
        st = 4'd0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_en(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      if (out_cmd_en) ok = 1;
    end
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      if (req_done != 0) ok = 1;
    end
  endtask

  task automatic wait_idle(input string name, input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      if (!out_busy) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int exp2[5] = '{0, 1, 2, 3, 0};
  bit ok;
  int c0, ec, dc, n0, d0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // 1: single request after reset
    @(posedge clk); #1;
    req_cmd[31:0] = 32'h00000021; req_valid = 4'b0001; c0 = cyc;
    wait_en(10, ok);
    chk("t1_en_seen", ok, 1);
    chk("t1_latency", cyc - c0, 1);
    chk("t1_data", out_cmd_data, 32'h00000021);
    chk("t1_ready", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_done(20, ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_done", req_done, 4'b0001);
    chk("t1_grant", out_grant_id, 0);
    wait_idle("t1_idle", 10);

    // 2: all requesters held valid -> 0,1,2,3,0
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) req_cmd[32*i +: 32] = 32'h00001011;
    req_valid = 4'b1111;
    for (int i = 0; i < 200 && grants.size() < 5; i++) @(posedge clk);
    #1 req_valid = '0;
    chk("t2_grant_count", grants.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t2_order%0d", k), (k < grants.size()) ? grants[k] : 32'hdead, exp2[k]);
    wait_idle("t2_idle", 50);

    // 6: one-cycle glitch on requester 3 during WAIT_DONE of requester 0
    fsm_exec = 10;
    @(posedge clk); #1;
    req_cmd[31:0] = 32'h00000060; req_valid = 4'b0001;
    wait_en(10, ok);
    chk("t6_en_seen", ok, 1);
    chk("t6_grant", out_grant_id, 0);
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 req_valid = 4'b1000;
    chk("t6_busy_glitch", out_busy, 1);
    n0 = en_cnt;
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t6_idle", 40);
    repeat (20) @(posedge clk);
    chk("t6_no_grant", en_cnt, n0);
    fsm_exec = 1;

    // 3: requester 2 with 500-cycle WAIT_TX stall
    fsm_pre = 500;
    @(posedge clk); #1;
    req_cmd[95:64] = 32'h00000033; req_valid = 4'b0100; n0 = en_cnt;
    wait_en(10, ok);
    ec = cyc;
    chk("t3_en_seen", ok, 1);
    chk("t3_grant", out_grant_id, 2);
    @(posedge clk); #1 req_valid = '0;
    wait_done(600, ok);
    dc = cyc;
    chk("t3_done_seen", ok, 1);
    chk("t3_done", req_done, 4'b0100);
    chk("t3_done_lat", dc - ec, 503);
    chk("t3_single_en", en_cnt - n0, 1);
    fsm_pre = 0;
    wait_idle("t3_idle", 10);

    // 5: FSM never acknowledges
    fsm_hang = 1'b1;
    @(posedge clk); #1;
    req_cmd[63:32] = 32'h00000055; req_valid = 4'b0010;
    wait_en(10, ok);
    ec = cyc;
    chk("t5_en_seen", ok, 1);
    @(posedge clk); #1 req_valid = '0;
`ifdef AH_PL2DDR_ARB_TIMEOUT_EN
    wait_done(100, ok);
    dc = cyc;
    chk("t5_done_seen", ok, 1);
    chk("t5_done", req_done, 4'b0010);
    chk("t5_tmo_lat", dc - ec, 64);
    @(posedge clk); #1;
    chk("t5_err_set", out_timeout_err, 1);
    in_err_clear = 1'b1;
    @(posedge clk); #1 in_err_clear = 1'b0;
    chk("t5_err_clr", out_timeout_err, 0);
`else
    repeat (200) @(posedge clk);
    #1;
    chk("t5_busy_hold", out_busy, 1);
    chk("t5_err_zero", out_timeout_err, 0);
    in_err_clear = 1'b1;
    @(posedge clk); #1 in_err_clear = 1'b0;
    chk("t5_err_ignore", out_timeout_err, 0);
`endif
    fsm_hang = 1'b0;
    do_reset();

    // 4: asynchronous reset during WAIT_DONE
    fsm_exec = 20;
    @(posedge clk); #1;
    req_cmd[31:0] = 32'h00000044; req_valid = 4'b0001;
    wait_en(10, ok);
    chk("t4_en_seen", ok, 1);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1 chk("t4_busy_before", out_busy, 1);
    d0 = done_cnt;
    #3 rst = 1'b0;
    #1;
    chk("t4_async_busy", out_busy, 0);
    chk("t4_async_data", out_cmd_data, 0);
    chk("t4_async_en", out_cmd_en, 0);
    chk("t4_async_done", req_done, 0);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    chk("t4_no_done", done_cnt, d0);
    fsm_exec = 1;
    req_cmd[63:32] = 32'h00000111; req_cmd[95:64] = 32'h00000222; req_valid = 4'b0110;
    wait_en(10, ok);
    chk("t4_en_seen2", ok, 1);
    chk("t4_grant", out_grant_id, 1);
    chk("t4_data", out_cmd_data, 32'h00000111);
    chk("t4_ready", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_en(20, ok);
    chk("t4_en_seen3", ok, 1);
    chk("t4_grant2", out_grant_id, 2);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t4_idle", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
